// File: rtl/kbfifo.sv
// Parametrised byte FIFO between a keycode producer and a CPU read register; reads register data in 1 cycle.
// Writes to a full FIFO are dropped and flagged in sticky overflow; reads of an empty FIFO return EMPTY_VALUE.
module kbfifo #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      ADDR_BITS   = 4,
  parameter logic [WIDTH-1:0] EMPTY_VALUE = {WIDTH{1'b0}},
  parameter int unsigned      AFULL_LEVEL = (1 << ADDR_BITS) - 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     wrdata,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rddata,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int unsigned      DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_CNT = (ADDR_BITS + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_BITS:0] PTR_ONE   = (ADDR_BITS + 1)'(1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_BITS:0] wr_ptr;
  logic [ADDR_BITS:0] rd_ptr;
  logic               wr_ok;
  logic               wr_drop;
  logic               rd_ok;

  // The extra pointer bit lets count reach DEPTH, so every entry is usable.
  assign count       = wr_ptr - rd_ptr;
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign almost_full = (count >= AFULL_CNT);

  assign wr_ok   = wr_en && !full  && !flush;
  assign wr_drop = wr_en &&  full  && !flush;
  assign rd_ok   = rd_en && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rddata   <= EMPTY_VALUE;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      end
      // Empty/full come from pre-edge state, so a write into an empty FIFO is never bypassed.
      if (rd_en && !flush) rddata <= empty ? EMPTY_VALUE : mem[rd_ptr[ADDR_BITS-1:0]];
      if (wr_drop)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[ADDR_BITS-1:0]] <= wrdata;
  end

endmodule

// File: doc/kbfifo.md
# kbfifo

Parametrised keyboard/byte FIFO, successor to the fixed 16×8 key buffer. It sits between a scancode/keycode producer (keyboard decoder or ESP link) and the CPU-visible I/O register. It adds configurable width and depth, use of all 2^ADDR_BITS entries, occupancy and status outputs, a sticky overflow flag with clear, and a synchronous flush. Reads keep the existing register semantics: data is registered and a read of an empty FIFO returns a fixed value.

## Interface
- WIDTH, 8: data width in bits.
- ADDR_BITS, 4: depth = 2^ADDR_BITS entries, all usable; legal range 2..8.
- EMPTY_VALUE, {WIDTH{1'b0}}: value returned by a read while empty.
- AFULL_LEVEL, 2^ADDR_BITS-2: almost_full asserts when count >= AFULL_LEVEL; legal range 1..2^ADDR_BITS.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- flush  in  1  synchronous clear of contents.
- wrdata  in  WIDTH  write data.
- wr_en  in  1  write strobe, one entry per cycle high.
- rd_en  in  1  read strobe, one entry per cycle high.
- rddata  out  WIDTH  registered read data.
- empty  out  1  count == 0.
- full  out  1  count == 2^ADDR_BITS.
- almost_full  out  1  count >= AFULL_LEVEL.
- count  out  ADDR_BITS+1  current occupancy, 0..2^ADDR_BITS.
- overflow  out  1  sticky flag: a write was dropped.
- ovf_clr  in  1  clears overflow.

## Operation
- Pointers: wr_ptr and rd_ptr are ADDR_BITS+1 bits wide. The memory index is the low ADDR_BITS bits. Both pointers wrap modulo 2^(ADDR_BITS+1).
- Occupancy: count = wr_ptr - rd_ptr, modulo 2^(ADDR_BITS+1). Register count, or derive it from the registered pointers; either way it must match this value.
- Status: empty, full and almost_full decode only from count. They are never combinational from wr_en or rd_en.
- Write: when wr_en=1 and full=0, store mem[wr_ptr] = wrdata and increment wr_ptr.
- Write when full: wr_en=1 with full=0 false drops the write and sets overflow. This applies even if rd_en=1 in the same cycle.
- Read: when rd_en=1, rddata is loaded on the next edge with mem[rd_ptr], or with EMPTY_VALUE if empty. rd_ptr increments only if the FIFO was not empty.
- rddata hold: rddata keeps its value in every cycle where rd_en=0.
- Simultaneous read and write: full and empty are taken from the state before the edge.
  - Not full and not empty: both complete and count is unchanged.
  - Empty: the write is stored and the read returns EMPTY_VALUE. No bypass; count becomes 1.
  - Full: the read completes, the write is dropped and overflow is set. count becomes DEPTH-1.
- Flush: flush=1 sets wr_ptr = rd_ptr = 0 on the next edge.
  - Flush has priority over wr_en and rd_en in the same cycle; neither takes effect.
  - rddata and overflow are unaffected by flush.
- Overflow clear: ovf_clr=1 clears overflow. If a dropped write occurs in the same cycle, the set wins and overflow stays 1.
- Reset: rst_n=0 asynchronously forces pointers=0, rddata=EMPTY_VALUE and overflow=0.
  - Resulting outputs: empty=1, full=0, count=0, almost_full=(AFULL_LEVEL==0 ? 1 : 0), which is 0 for legal values.
  - Memory contents are not reset.
  - Reset during an in-progress read or write discards that access.
- Memory: an inferred distributed or block RAM with a synchronous write port. The read may be asynchronous into the rddata register.

## Timing
- Write latency: data written at edge N can be read with rd_en at edge N+1. rddata is valid after edge N+1, so the minimum write-to-data latency is 2 cycles.
- Read latency: 1 cycle, from the rd_en edge to rddata valid.
- Status timing: empty, full, almost_full and count update the cycle after the edge causing the change.
- Reset release: rst_n deassertion is synchronised by the integrating level. The block requires only that rst_n is released at least one cycle before the first wr_en or rd_en.
- Throughput: sustained one write plus one read per cycle.

## Test plan
- Reset, then 3 writes (0x41, 0x42, 0x43), then 3 reads → rddata = 0x41, 0x42, 0x43 on consecutive cycles. count goes 3→0; empty=1 at the end.
- Fill 16 entries (ADDR_BITS=4), then a 17th write of 0xFF → full=1, count=16, overflow=1. A drain returns the first 16 values in order; 0xFF never appears.
- Read while empty with EMPTY_VALUE=0x00 → rddata=0x00, rd_ptr unchanged, count stays 0.
- Simultaneous wr_en and rd_en:
  - When empty: read returns 0x00 and count=1.
  - When full: count=15 and overflow=1.
  - At count=5: count stays 5 over 20 cycles and the data order is preserved.
- Wrap-around: 40 interleaved writes and reads at an average occupancy of about 7 → all values come out in order with no loss. count never exceeds 16. almost_full asserts exactly when count >= 14.
- Flush with wr_en=1 at count=9 → count=0 and empty=1, with the written value discarded; overflow unchanged.
  - ovf_clr and an overflowing write in the same cycle → overflow stays 1.
  - rst_n pulsed low mid-burst → outputs return to their reset values immediately, without waiting for a clock edge.
